// File: rtl/mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mac_seq_ctrl
// Brief    : Job sequencer for a dual-lane multiply-accumulate PE. Latches a
//            dot-product job, clears the PE, streams packed operand pairs from
//            the activation/weight buffers, waits for the PE to drain and
//            offers the captured accumulator on a valid/ready port.
// Options  : MAC_SEQ_PERF_EN adds saturating busy-cycle and job counters.
// Revision : 1.0 - initial release
// ============================================================================
module mac_seq_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    len,
  input  logic [ADDR_WIDTH-1:0]   base_a,
  input  logic [ADDR_WIDTH-1:0]   base_w,
  output logic                    busy,
  output logic                    a_rd_en,
  output logic [ADDR_WIDTH-1:0]   a_rd_addr,
  input  logic [2*DATA_WIDTH-1:0] a_rd_data,
  output logic                    w_rd_en,
  output logic [ADDR_WIDTH-1:0]   w_rd_addr,
  input  logic [2*DATA_WIDTH-1:0] w_rd_data,
  output logic                    pe_clear,
  output logic [DATA_WIDTH-1:0]   pe_a1,
  output logic [DATA_WIDTH-1:0]   pe_a2,
  output logic [DATA_WIDTH-1:0]   pe_w1,
  output logic [DATA_WIDTH-1:0]   pe_w2,
  input  logic [ACC_WIDTH-1:0]    pe_acc,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ACC_WIDTH-1:0]    res_data
`ifdef MAC_SEQ_PERF_EN
  ,
  output logic [31:0]             perf_busy_cycles,
  output logic [15:0]             perf_jobs
`endif
);

  localparam logic [LEN_WIDTH-1:0] C_LEN_ONE = LEN_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    DRAIN0 = 3'd3,
    DRAIN1 = 3'd4,
    OUT    = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_base_a;
  logic [ADDR_WIDTH-1:0]   r_base_w;
  logic [LEN_WIDTH-1:0]    r_pairs;      // P = ceil(len/2)
  logic                    r_odd;        // len odd: last pair has no elem1
  logic [LEN_WIDTH-1:0]    r_idx;        // pair index being issued
  logic                    r_dv;         // read data arrives this cycle
  logic                    r_last_odd;   // this data cycle is the masked pair
  logic [ACC_WIDTH-1:0]    r_res;
  logic [LEN_WIDTH:0]      w_len_p1;
  logic                    w_last_issue;

  // One extra bit so len = all-ones still rounds up correctly.
  assign w_len_p1     = {1'b0, len} + {{LEN_WIDTH{1'b0}}, 1'b1};
  assign w_last_issue = (r_idx == (r_pairs - C_LEN_ONE));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Latch the job parameters when a start is accepted in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base_a <= '0;
      r_base_w <= '0;
      r_pairs  <= '0;
      r_odd    <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_base_a <= base_a;
      r_base_w <= base_w;
      r_pairs  <= w_len_p1[LEN_WIDTH:1];
      r_odd    <= len[0];
    end
  end

  // Issue counter plus the one-cycle-delayed data-valid/last-odd tags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx      <= '0;
      r_dv       <= 1'b0;
      r_last_odd <= 1'b0;
    end else begin
      if (r_state == CLEAR)    r_idx <= '0;
      else if (r_state == RUN) r_idx <= r_idx + C_LEN_ONE;
      r_dv       <= (r_state == RUN);
      r_last_odd <= (r_state == RUN) && w_last_issue && r_odd;
    end
  end

  // Capture the drained accumulator at the end of DRAIN1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               r_res <= '0;
    else if (r_state == DRAIN1) r_res <= pe_acc;
  end

  // Next-state and all combinational outputs.
  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != IDLE);
    res_valid   = (r_state == OUT);
    res_data    = r_res;
    // Held high during reset so the PE clears on the clock edges in reset.
    pe_clear    = (r_state == CLEAR) || !reset_n;
    a_rd_en     = 1'b0;
    w_rd_en     = 1'b0;
    a_rd_addr   = '0;
    w_rd_addr   = '0;
    pe_a1       = '0;
    pe_a2       = '0;
    pe_w1       = '0;
    pe_w2       = '0;

    if (r_state == RUN) begin
      a_rd_en   = 1'b1;
      w_rd_en   = 1'b1;
      a_rd_addr = r_base_a + ADDR_WIDTH'(r_idx);
      w_rd_addr = r_base_w + ADDR_WIDTH'(r_idx);
    end

    // The PE accumulates every cycle, so operands are zero outside data cycles.
    if (r_dv) begin
      pe_a1 = a_rd_data[DATA_WIDTH-1:0];
      pe_w1 = w_rd_data[DATA_WIDTH-1:0];
      if (!r_last_odd) begin
        pe_a2 = a_rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
        pe_w2 = w_rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
      end
    end

    case (r_state)
      IDLE:    if (start) w_state_nxt = CLEAR;
      CLEAR:   w_state_nxt = (r_pairs != '0) ? RUN : DRAIN0;
      RUN:     if (w_last_issue) w_state_nxt = DRAIN0;
      DRAIN0:  w_state_nxt = DRAIN1;
      DRAIN1:  w_state_nxt = OUT;
      OUT:     if (res_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef MAC_SEQ_PERF_EN
  // Saturating performance counters; only reset clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_busy_cycles <= '0;
      perf_jobs        <= '0;
    end else begin
      if (busy && (perf_busy_cycles != '1))
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (res_valid && res_ready && (perf_jobs != '1))
        perf_jobs <= perf_jobs + 16'd1;
    end
  end
`else
  // Performance counters not built.
`endif

endmodule
`default_nettype wire

// File: tb/tb_mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_seq_ctrl
// Brief    : Directed self-checking bench for mac_seq_ctrl with buffer and
//            PE behavioural models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [10:0] len;
  logic [9:0]  base_a, base_w;
  logic        busy;
  logic        a_rd_en, w_rd_en;
  logic [9:0]  a_rd_addr, w_rd_addr;
  logic [15:0] a_rd_data, w_rd_data;
  logic        pe_clear;
  logic [7:0]  pe_a1, pe_a2, pe_w1, pe_w2;
  logic [31:0] pe_acc;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
`ifdef MAC_SEQ_PERF_EN
  logic [31:0] perf_busy_cycles;
  logic [15:0] perf_jobs;
`endif

  logic [15:0] a_mem [0:1023];
  logic [15:0] w_mem [0:1023];
  int n_checks = 0;
  int n_errors = 0;

  mac_seq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len),
    .base_a(base_a), .base_w(base_w), .busy(busy),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .pe_clear(pe_clear), .pe_a1(pe_a1), .pe_a2(pe_a2), .pe_w1(pe_w1),
    .pe_w2(pe_w2), .pe_acc(pe_acc), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data)
`ifdef MAC_SEQ_PERF_EN
    , .perf_busy_cycles(perf_busy_cycles), .perf_jobs(perf_jobs)
`endif
  );

  always #5 clk = ~clk;

  // Buffer models: one-cycle read latency.
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
    if (w_rd_en) w_rd_data <= w_mem[w_rd_addr];
  end

  // PE model: synchronous clear, signed dual-lane accumulate every cycle.
  logic signed [15:0] p1, p2;
  assign p1 = $signed(pe_a1) * $signed(pe_w1);
  assign p2 = $signed(pe_a2) * $signed(pe_w2);
  always @(posedge clk) begin
    if (pe_clear) pe_acc <= 32'd0;
    else          pe_acc <= pe_acc + {{16{p1[15]}}, p1} + {{16{p2[15]}}, p2};
  end

  // Call at a negedge: start is seen this cycle (cycle 0); returns in cycle 1.
  task automatic start_job(input logic [10:0] l, input logic [9:0] ba, input logic [9:0] bw);
    start = 1'b1; len = l; base_a = ba; base_w = bw;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; len = '0; base_a = '0; base_w = '0; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({pe_clear, busy, a_rd_en, w_rd_en, res_valid} !== 5'b10000) begin
      n_errors++; $display("FAIL reset_ctrl: got %b expected 10000", {pe_clear, busy, a_rd_en, w_rd_en, res_valid});
    end
    n_checks++;
    if ({res_data, pe_a1, pe_a2, pe_w1, pe_w2, a_rd_addr, w_rd_addr} !== '0) begin
      n_errors++; $display("FAIL reset_data: res_data %h ops %h%h%h%h expected all 0", res_data, pe_a1, pe_a2, pe_w1, pe_w2);
    end
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (pe_clear !== 1'b0) begin
      n_errors++; $display("FAIL release_pe_clear: got %b expected 0", pe_clear);
    end
    @(negedge clk);
    n_checks++;
    if ({pe_clear, busy, a_rd_en, w_rd_en, res_valid} !== 5'b00000) begin
      n_errors++; $display("FAIL idle_ctrl: got %b expected 00000", {pe_clear, busy, a_rd_en, w_rd_en, res_valid});
    end
  endtask

  task automatic test_len4;
    a_mem[0] = 16'h0201; a_mem[1] = 16'h0403;
    w_mem[32] = 16'h0605; w_mem[33] = 16'h0807;
    start_job(11'd4, 10'h000, 10'h020);
    n_checks++;
    if ({busy, pe_clear, a_rd_en} !== 3'b110) begin
      n_errors++; $display("FAIL len4_clear: got %b expected 110", {busy, pe_clear, a_rd_en});
    end
    @(negedge clk); // cycle 2
    n_checks++;
    if ({a_rd_en, w_rd_en, a_rd_addr, w_rd_addr} !== {2'b11, 10'h000, 10'h020}) begin
      n_errors++; $display("FAIL len4_issue0: en %b%b addr %h/%h expected 11 000/020", a_rd_en, w_rd_en, a_rd_addr, w_rd_addr);
    end
    @(negedge clk); // cycle 3
    n_checks++;
    if ({a_rd_addr, w_rd_addr, pe_a1, pe_w1, pe_a2, pe_w2} !== {10'h001, 10'h021, 8'd1, 8'd5, 8'd2, 8'd6}) begin
      n_errors++; $display("FAIL len4_data0: addr %h/%h ops %0d %0d %0d %0d expected 001/021 1 5 2 6", a_rd_addr, w_rd_addr, pe_a1, pe_w1, pe_a2, pe_w2);
    end
    @(negedge clk); // cycle 4
    n_checks++;
    if ({a_rd_en, pe_a1, pe_w1, pe_a2, pe_w2} !== {1'b0, 8'd3, 8'd7, 8'd4, 8'd8}) begin
      n_errors++; $display("FAIL len4_data1: en %b ops %0d %0d %0d %0d expected 0 3 7 4 8", a_rd_en, pe_a1, pe_w1, pe_a2, pe_w2);
    end
    @(negedge clk); // cycle 5
    n_checks++;
    if ({res_valid, pe_a1, pe_a2, pe_w1, pe_w2} !== '0) begin
      n_errors++; $display("FAIL len4_drain1: valid %b ops %h%h%h%h expected 0 and zero ops", res_valid, pe_a1, pe_a2, pe_w1, pe_w2);
    end
    @(negedge clk); // cycle 6
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== 32'd70) begin
      n_errors++; $display("FAIL len4_result: valid %b data %0d expected 1 70", res_valid, res_data);
    end
    @(negedge clk);
    n_checks++;
    if ({busy, res_valid} !== 2'b00) begin
      n_errors++; $display("FAIL len4_done: busy/valid %b expected 00", {busy, res_valid});
    end
  endtask

  task automatic test_len3_odd;
    a_mem[256] = 16'h7F80; a_mem[257] = 16'h7FFF;
    w_mem[512] = 16'h8080; w_mem[513] = 16'h7F05;
    start_job(11'd3, 10'h100, 10'h200);
    @(negedge clk); @(negedge clk); // cycle 3
    n_checks++;
    if ({pe_a1, pe_w1, pe_a2, pe_w2} !== 32'h80807F80) begin
      n_errors++; $display("FAIL odd_pair0: ops %h expected 80807f80", {pe_a1, pe_w1, pe_a2, pe_w2});
    end
    @(negedge clk); // cycle 4
    n_checks++;
    if ({pe_a1, pe_w1, pe_a2, pe_w2} !== 32'hFF050000) begin
      n_errors++; $display("FAIL odd_mask: ops %h expected ff050000", {pe_a1, pe_w1, pe_a2, pe_w2});
    end
    @(negedge clk); @(negedge clk); // cycle 6
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== 32'd123) begin
      n_errors++; $display("FAIL odd_result: valid %b data %0d expected 1 123", res_valid, res_data);
    end
    @(negedge clk);
  endtask

  task automatic test_len0;
    start_job(11'd0, 10'h0AA, 10'h0BB);
    @(negedge clk); // cycle 2
    n_checks++;
    if ({a_rd_en, w_rd_en} !== 2'b00) begin
      n_errors++; $display("FAIL len0_noread2: en %b expected 00", {a_rd_en, w_rd_en});
    end
    @(negedge clk); // cycle 3
    n_checks++;
    if ({a_rd_en, w_rd_en, res_valid} !== 3'b000) begin
      n_errors++; $display("FAIL len0_cycle3: en/valid %b expected 000", {a_rd_en, w_rd_en, res_valid});
    end
    @(negedge clk); // cycle 4
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== 32'd0) begin
      n_errors++; $display("FAIL len0_result: valid %b data %0d expected 1 0", res_valid, res_data);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    a_mem[16] = 16'h0302; w_mem[48] = 16'h0405;
    res_ready = 1'b0;
    start_job(11'd2, 10'h010, 10'h030);
    repeat (4) @(negedge clk); // cycle 5
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== 32'd22) begin
      n_errors++; $display("FAIL bp_first: valid %b data %0d expected 1 22", res_valid, res_data);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin start = 1'b1; len = 11'd8; base_a = 10'h055; end
      if (i == 4) start = 1'b0;
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b1 || res_data !== 32'd22 || busy !== 1'b1) begin
        n_errors++; $display("FAIL bp_hold%0d: valid %b busy %b data %0d expected 1 1 22", i, res_valid, busy, res_data);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, res_valid} !== 2'b00) begin
      n_errors++; $display("FAIL bp_release: busy/valid %b expected 00", {busy, res_valid});
    end
    start_job(11'd2, 10'h010, 10'h030);
    n_checks++;
    if ({busy, pe_clear} !== 2'b11) begin
      n_errors++; $display("FAIL bp_restart: busy/clear %b expected 11", {busy, pe_clear});
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== 32'd22) begin
      n_errors++; $display("FAIL bp_second: valid %b data %0d expected 1 22", res_valid, res_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_job;
    logic seen_valid;
    start_job(11'd16, 10'h3FE, 10'h050);
    @(negedge clk); // cycle 2
    n_checks++;
    if (a_rd_addr !== 10'h3FE) begin
      n_errors++; $display("FAIL wrap_addr0: got %h expected 3fe", a_rd_addr);
    end
    @(negedge clk); @(negedge clk); // cycle 4
    n_checks++;
    if (a_rd_addr !== 10'h000 || w_rd_addr !== 10'h052) begin
      n_errors++; $display("FAIL wrap_addr2: got %h/%h expected 000/052", a_rd_addr, w_rd_addr);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, a_rd_en, w_rd_en, pe_clear, res_valid} !== 5'b00010 ||
        {res_data, pe_a1, pe_a2, pe_w1, pe_w2, a_rd_addr, w_rd_addr} !== '0) begin
      n_errors++; $display("FAIL abort_outputs: ctrl %b data %h addr %h ops %h%h%h%h expected 00010 and zeros",
        {busy, a_rd_en, w_rd_en, pe_clear, res_valid}, res_data, a_rd_addr, pe_a1, pe_a2, pe_w1, pe_w2);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b0) seen_valid = 1'b1;
    end
    n_checks++;
    if (seen_valid) begin
      n_errors++; $display("FAIL abort_no_result: busy or res_valid seen after abort, expected none");
    end
    start_job(11'd2, 10'h010, 10'h030);
    repeat (4) @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== 32'd22) begin
      n_errors++; $display("FAIL abort_fresh: valid %b data %0d expected 1 22", res_valid, res_data);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin a_mem[i] = 16'h0; w_mem[i] = 16'h0; end
    test_reset();
    @(negedge clk);
    test_len4();
    @(negedge clk);
    test_len3_odd();
    test_len0();
    test_backpressure();
    test_reset_mid_job();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
